// File: rtl/point_stream_sequencer.sv
// Parses a UART byte stream into 32-bit point words, buffers them in a FIFO and issues
// them to the line-draw controller as one-cycle draw/jump pulses with a holdoff between issues.
module point_stream_sequencer #(
    parameter int FIFO_DEPTH     = 64,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int HOLDOFF        = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          ready,
    output logic                          draw,
    output logic                          jump,
    output logic [11:0]                   x,
    output logic [11:0]                   y,
    output logic                          frame_active,
    output logic                          frame_end,
    output logic                          overflow,
    output logic                          rx_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [31:0]   DONE_WORD    = 32'h0101_0101;
    localparam logic [LW-1:0] DEPTH        = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLDOFF - 1);

    typedef enum logic {RX_WAIT, RX_FRAME} rx_state_t;
    typedef enum logic {IS_IDLE, IS_HOLD} is_state_t;

    rx_state_t       rx_state;
    is_state_t       is_state;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift_reg;
    logic [TW-1:0]   idle_timer;
    logic [HW-1:0]   hold_cnt;

    logic [24:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [24:0]     head;

    logic [31:0]     word;
    logic            word_done;
    logic            is_done;
    logic            is_point;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            drop;
    logic            timeout;

    // The done word is matched before the op field, since it would otherwise decode as a draw.
    assign word       = {shift_reg, rx_byte};
    assign word_done  = (rx_state == RX_FRAME) && rx_valid && (byte_cnt == 2'd3);
    assign is_done    = word_done && (word == DONE_WORD);
    assign is_point   = word_done && !is_done && !word[31];
    assign fifo_full  = (fifo_level == DEPTH);
    assign fifo_empty = (fifo_level == '0);
    assign pop        = (is_state == IS_IDLE) && ready && !fifo_empty;
    assign push       = is_point && (!fifo_full || pop);
    assign drop       = is_point && fifo_full && !pop;
    assign timeout    = (byte_cnt != 2'd0) && !rx_valid && (idle_timer == TIMEOUT_LAST);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state     <= RX_WAIT;
            byte_cnt     <= 2'd0;
            shift_reg    <= 24'h0;
            idle_timer   <= '0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            overflow     <= 1'b0;
            rx_error     <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            rx_error  <= 1'b0;
            if (rx_valid || byte_cnt == 2'd0) begin
                idle_timer <= '0;
            end else if (idle_timer != TIMEOUT_LAST) begin
                idle_timer <= idle_timer + TW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (rx_state)
                RX_WAIT: begin
                    if (rx_valid && rx_byte != 8'h00) begin
                        shift_reg    <= {shift_reg[15:0], rx_byte};
                        byte_cnt     <= 2'd1;
                        rx_state     <= RX_FRAME;
                        frame_active <= 1'b1;
                        overflow     <= 1'b0;
                    end
                end
                RX_FRAME: begin
                    if (rx_valid) begin
                        // byte_cnt wraps from 3 back to 0 when a word completes
                        shift_reg <= {shift_reg[15:0], rx_byte};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (is_done) begin
                            frame_end    <= 1'b1;
                            rx_state     <= RX_WAIT;
                            frame_active <= 1'b0;
                        end
                    end else if (timeout) begin
                        rx_error     <= 1'b1;
                        byte_cnt     <= 2'd0;
                        rx_state     <= RX_WAIT;
                        frame_active <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // Storage keeps only the jump flag and the coordinates.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= {word[30], word[23:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            is_state <= IS_IDLE;
            hold_cnt <= '0;
            draw     <= 1'b0;
            jump     <= 1'b0;
            x        <= 12'h0;
            y        <= 12'h0;
        end else begin
            draw <= 1'b0;
            jump <= 1'b0;
            case (is_state)
                IS_IDLE: begin
                    if (pop) begin
                        x        <= head[23:12];
                        y        <= head[11:0];
                        draw     <= !head[24];
                        jump     <= head[24];
                        hold_cnt <= '0;
                        is_state <= IS_HOLD;
                    end
                end
                IS_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        is_state <= IS_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_point_stream_sequencer.sv
// Randomised and directed bench for point_stream_sequencer: a byte-level frame model feeds a
// scoreboard of expected points that a monitor matches against every draw/jump pulse.
module tb_point_stream_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HOLD  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          ready = 1'b0;
    logic          draw;
    logic          jump;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          frame_active;
    logic          frame_end;
    logic          overflow;
    logic          rx_error;
    logic [LW-1:0] fifo_level;

    point_stream_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .ready(ready),
        .draw(draw),
        .jump(jump),
        .x(x),
        .y(y),
        .frame_active(frame_active),
        .frame_end(frame_end),
        .overflow(overflow),
        .rx_error(rx_error),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        jmp;
        logic [11:0] px;
        logic [11:0] py;
    } point_t;

    point_t     sb[$];
    logic [7:0] m_bytes[$];
    bit         m_active;
    bit         m_ovf;
    bit         rand_ready;
    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         last_pulse = -1;
    int         pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_bytes.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Frame-level reference: collect bytes, decode whole words, queue the points that should issue.
    task automatic model_byte(input logic [7:0] b, input bit pop_now, output bit exp_fe);
        logic [31:0] w;
        exp_fe = 1'b0;
        if (!m_active) begin
            if (b != 8'h00) begin
                m_active = 1'b1;
                m_ovf    = 1'b0;
                m_bytes.delete();
                m_bytes.push_back(b);
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                if (w == 32'h0101_0101) begin
                    exp_fe   = 1'b1;
                    m_active = 1'b0;
                end else if (w[31] == 1'b0) begin
                    if (sb.size() >= DEPTH && !pop_now) m_ovf = 1'b1;
                    else sb.push_back({w[30], w[23:12], w[11:0]});
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap, input bit go_ready);
        bit exp_fe;
        @(negedge clk);
        model_byte(b, go_ready, exp_fe);
        rx_valid = 1'b1;
        rx_byte  = b;
        if (go_ready) ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("frame_end", frame_end, exp_fe);
        checkOutput("frame_active", frame_active, m_active);
        checkOutput("overflow", overflow, m_ovf);
        checkOutput("rx_error_quiet", rx_error, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        applyStimulus(w[31:24], gap, 1'b0);
        applyStimulus(w[23:16], gap, 1'b0);
        applyStimulus(w[15:8], gap, 1'b0);
        applyStimulus(w[7:0], gap, 1'b0);
    endtask

    // First byte always nonzero and never 0x01, so it opens a frame and is never a done word.
    function automatic logic [31:0] rand_point();
        logic [11:0] px;
        logic [11:0] py;
        logic        op;
        px = 12'($urandom);
        py = 12'($urandom);
        op = 1'($urandom);
        return {1'b0, op, 1'b1, 5'($urandom), px, py};
    endfunction

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_draw"}, draw, 0);
        checkOutput({tag, "_jump"}, jump, 0);
        checkOutput({tag, "_x"}, x, 0);
        checkOutput({tag, "_y"}, y, 0);
        checkOutput({tag, "_frame_active"}, frame_active, 0);
        checkOutput({tag, "_frame_end"}, frame_end, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_rx_error"}, rx_error, 0);
        checkOutput({tag, "_fifo_level"}, fifo_level, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        rand_ready = 1'b0;
        ready = 1'b1;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", sb.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    // Monitor: every pulse must be the oldest expected point and respect the holdoff spacing.
    initial begin
        point_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!reset_n) begin
                last_pulse = -1;
            end else if (draw || jump) begin
                checkOutput("draw_jump_exclusive", draw & jump, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got draw=%0b jump=%0b x=%0h y=%0h, expected none",
                             draw, jump, x, y);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pulse_jump", jump, e.jmp);
                    checkOutput("pulse_x", x, e.px);
                    checkOutput("pulse_y", y, e.py);
                end
                if (last_pulse >= 0)
                    checkOutput("pulse_spacing", (cycle - last_pulse) >= HOLD + 1, 1);
                last_pulse = cycle;
                pulses++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) ready = 1'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  leading[8];
        logic [31:0] w;
        int          p0;
        int          n;
        bit          early;
        bit          seen;
        int          kind;

        model_clear();
        rand_ready = 1'b0;

        // Reset held while bytes keep arriving.
        repeat (4) begin
            @(negedge clk);
            rx_valid = 1'($urandom);
            rx_byte  = 8'($urandom);
            ready    = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check_reset_outputs("reset_traffic");
        @(negedge clk);
        rx_valid = 1'b0;
        ready    = 1'b0;
        reset_n  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_frame_active", frame_active, 0);
        checkOutput("idle_fifo_level", fifo_level, 0);

        // Leading zeros, one draw, then the done word.
        leading = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00, 8'h30};
        foreach (leading[i]) applyStimulus(leading[i], 0, 1'b0);
        wait_drain(50);
        send_word(32'h0101_0101, 1);

        // Jump word queues, reserved word does not.
        ready = 1'b0;
        send_word(32'h4000_0507, 0);
        checkOutput("level_after_jump", fifo_level, 1);
        send_word(32'h8011_2233, 0);
        checkOutput("level_after_reserved", fifo_level, 1);
        wait_drain(50);

        // Overfill with ready low, then drain in order.
        ready = 1'b0;
        p0 = pulses;
        repeat (DEPTH + 1) send_word(rand_point(), 0);
        checkOutput("full_level", fifo_level, DEPTH);
        checkOutput("full_overflow", overflow, 1);
        wait_drain(DEPTH * (HOLD + 1) + 50);
        checkOutput("drain_count", pulses - p0, DEPTH);

        // Partial word abandoned long enough to time out.
        applyStimulus(8'h25, 0, 1'b0);
        applyStimulus(8'h11, 0, 1'b0);
        early = 1'b0;
        repeat (TMO - 5) begin
            @(posedge clk);
            #1;
            if (rx_error) early = 1'b1;
        end
        checkOutput("rx_error_early", early, 0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (rx_error) seen = 1'b1;
        end
        checkOutput("rx_error_pulse", seen, 1);
        checkOutput("timeout_latency_ok", (n >= 4 && n <= 6), 1);
        checkOutput("frame_active_after_timeout", frame_active, 0);
        @(posedge clk);
        #1;
        checkOutput("rx_error_single_cycle", rx_error, 0);
        m_active = 1'b0;
        m_bytes.delete();
        send_word(rand_point(), 1);
        wait_drain(50);

        // Full FIFO: the completing byte lands on the same edge as a pop.
        do_reset();
        ready = 1'b0;
        repeat (DEPTH) send_word(rand_point(), 0);
        checkOutput("prefill_level", fifo_level, DEPTH);
        w = rand_point();
        applyStimulus(w[31:24], 0, 1'b0);
        applyStimulus(w[23:16], 0, 1'b0);
        applyStimulus(w[15:8], 0, 1'b0);
        applyStimulus(w[7:0], 0, 1'b1);
        checkOutput("pop_push_level", fifo_level, DEPTH);
        checkOutput("pop_push_overflow", overflow, 0);
        wait_drain(DEPTH * (HOLD + 1) + 50);

        // Reset during the holdoff after a pulse.
        ready = 1'b0;
        repeat (4) send_word(rand_point(), 0);
        ready = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (draw || jump) seen = 1'b1;
        end
        checkOutput("hold_pulse_seen", seen, 1);
        do_reset();
        ready = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("after_hold_reset_level", fifo_level, 0);

        // Random traffic with random ready.
        rand_ready = 1'b1;
        repeat (60) begin
            if (sb.size() > DEPTH - 2) begin
                rand_ready = 1'b0;
                ready = 1'b1;
                n = 0;
                while (sb.size() > DEPTH - 2 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("room_wait", sb.size() <= DEPTH - 2, 1);
                rand_ready = 1'b1;
            end
            kind = $urandom_range(0, 19);
            if (kind < 12) begin
                w = {2'b00, 6'($urandom), 24'($urandom)};
                w[30] = 1'($urandom);
                if (w == 32'h0101_0101) w[0] = 1'b0;
                send_word(w, $urandom_range(0, 3));
            end else if (kind < 15) begin
                send_word({2'b10, 30'($urandom)} | (32'($urandom_range(0, 1)) << 30), $urandom_range(0, 3));
            end else if (kind < 18) begin
                send_word(32'h0101_0101, $urandom_range(0, 3));
            end else begin
                applyStimulus(8'h00, $urandom_range(0, 3), 1'b0);
            end
        end
        send_word(32'h0101_0101, 0);
        wait_drain(DEPTH * (HOLD + 1) + 100);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
